audio_echo_delay: RTL and testbench

AUDIO_ECHO_DELAY -- requirements
Module: audio_echo_delay

---
 rtl/audio_echo_delay.sv | 116 +++++++++++
 tb/tb_audio_echo_delay.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_echo_delay.sv
// Single-tap echo: each accepted sample is written to a ring buffer and mixed with an
// attenuated copy of the sample written delay_len accepts earlier, with saturation.
module audio_echo_delay #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic [2:0]        gain_shift,
    input  logic              enable,
    output logic [DATA_W-1:0] sample_out,
    output logic              out_valid,
    output logic [ADDR_W-1:0] fill_cnt
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] FILL_MAX = '1;
    localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] rd_addr;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_sample_q, s1_sample_d;
    logic [2:0]        s1_gain_q, s1_gain_d;
    logic              s1_use_echo_q, s1_use_echo_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] sample_out_q, sample_out_d;

    logic signed [DATA_W-1:0] delayed;
    logic [DATA_W:0]          sum;

    // Buffer RAM kept free of reset so it maps onto block memory; read is registered.
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            mem[wr_ptr_q] <= sample_in;
            rd_data_q     <= mem[rd_addr];
        end
    end

    always_comb begin
        rd_addr       = wr_ptr_q - delay_len;
        wr_ptr_d      = wr_ptr_q;
        fill_cnt_d    = fill_cnt_q;
        s1_valid_d    = sample_valid;
        s1_sample_d   = s1_sample_q;
        s1_gain_d     = s1_gain_q;
        s1_use_echo_d = s1_use_echo_q;

        if (sample_valid) begin
            wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
            s1_sample_d = sample_in;
            s1_gain_d   = gain_shift;
            // Guard against reading slots not yet written since reset.
            s1_use_echo_d = enable && (delay_len != '0) && (delay_len <= fill_cnt_q);
            if (fill_cnt_q != FILL_MAX) begin
                fill_cnt_d = fill_cnt_q + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        delayed      = '0;
        out_valid_d  = s1_valid_q;
        sample_out_d = sample_out_q;

        if (s1_use_echo_q) begin
            delayed = $signed(rd_data_q) >>> s1_gain_q;
        end
        sum = {s1_sample_q[DATA_W-1], s1_sample_q} + {delayed[DATA_W-1], delayed};

        if (s1_valid_q) begin
            if (sum[DATA_W] != sum[DATA_W-1]) begin
                sample_out_d = sum[DATA_W] ? SAT_MIN : SAT_MAX;
            end else begin
                sample_out_d = sum[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            fill_cnt_q    <= '0;
            s1_valid_q    <= 1'b0;
            s1_sample_q   <= '0;
            s1_gain_q     <= '0;
            s1_use_echo_q <= 1'b0;
            out_valid_q   <= 1'b0;
            sample_out_q  <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            fill_cnt_q    <= fill_cnt_d;
            s1_valid_q    <= s1_valid_d;
            s1_sample_q   <= s1_sample_d;
            s1_gain_q     <= s1_gain_d;
            s1_use_echo_q <= s1_use_echo_d;
            out_valid_q   <= out_valid_d;
            sample_out_q  <= sample_out_d;
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign fill_cnt   = fill_cnt_q;

endmodule

// File: tb/tb_audio_echo_delay.sv
// Directed bench for audio_echo_delay: bypass, echo, saturation, fill guard,
// buffer wrap and reset in mid-stream, with hand-derived expected outputs.
module tb_audio_echo_delay;

    logic        clk;
    logic        reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [11:0] delay_len;
    logic [2:0]  gain_shift;
    logic        enable;
    logic [15:0] sample_out;
    logic        out_valid;
    logic [11:0] fill_cnt;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int out_q[$];
    int pulse_cnt = 0;

    int base;
    int pulse_snap;
    int exp_echo[8] = '{8000, 0, 0, 0, 4000, 0, 0, 0};
    int exp_sat[4]  = '{30000, 32767, 0, -32768};
    int exp_ctl[5]  = '{-7, -4, 100, 43, 25};

    audio_echo_delay #(.DATA_W(16), .ADDR_W(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .delay_len   (delay_len),
        .gain_shift  (gain_shift),
        .enable      (enable),
        .sample_out  (sample_out),
        .out_valid   (out_valid),
        .fill_cnt    (fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect every qualified output, sampled on the falling edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            out_q.push_back(int'($signed(sample_out)));
            pulse_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        total_cnt++;
        if (observed !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input int s, input int d, input int g,
                                 input logic e);
        @(negedge clk);
        sample_valid = v;
        sample_in    = 16'(s);
        delay_len    = 12'(d);
        gain_shift   = 3'(g);
        enable       = e;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        sample_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int getOut(input int idx);
        if (idx < out_q.size()) return out_q[idx];
        return -999999;
    endfunction

    function automatic int wrapIn(input int i);
        return (i % 200) * 10 - 1000;
    endfunction

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        delay_len    = '0;
        gain_shift   = '0;
        enable       = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_sample_out", $signed(sample_out), 0);
        checkOutput("rst_fill_cnt", fill_cnt, 0);

        $display("[TB] bypass");
        applyStimulus(1'b1, 1000, 0, 0, 1'b1);
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        checkOutput("byp_early", out_valid, 0);
        @(negedge clk);
        checkOutput("byp_valid", out_valid, 1);
        checkOutput("byp_data", $signed(sample_out), 1000);
        @(negedge clk);
        checkOutput("byp_width", out_valid, 0);
        checkOutput("byp_fill", fill_cnt, 1);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 555, 0, 0, 1'b1);
        @(negedge clk);
        pulse_snap   = pulse_cnt;
        sample_valid = 1'b0;
        reset        = 1'b1;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_sample_out", $signed(sample_out), 0);
        checkOutput("midrst_fill", fill_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        idleCycles(4);
        checkOutput("midrst_no_pulse", pulse_cnt - pulse_snap, 0);
        base = out_q.size();
        applyStimulus(1'b1, 77, 0, 0, 1'b1);
        idleCycles(3);
        checkOutput("postrst_count", out_q.size() - base, 1);
        checkOutput("postrst_data", getOut(base), 77);
        checkOutput("postrst_fill", fill_cnt, 1);

        $display("[TB] echo");
        doReset();
        base = out_q.size();
        applyStimulus(1'b1, 8000, 4, 1, 1'b1);
        for (int i = 1; i < 8; i++) applyStimulus(1'b1, 0, 4, 1, 1'b1);
        idleCycles(3);
        checkOutput("echo_count", out_q.size() - base, 8);
        for (int i = 0; i < 8; i++) checkOutput($sformatf("echo_%0d", i), getOut(base + i), exp_echo[i]);

        $display("[TB] saturation");
        doReset();
        base = out_q.size();
        applyStimulus(1'b1, 30000, 1, 0, 1'b1);
        applyStimulus(1'b1, 30000, 1, 0, 1'b1);
        applyStimulus(1'b1, -30000, 1, 0, 1'b1);
        applyStimulus(1'b1, -30000, 1, 0, 1'b1);
        idleCycles(3);
        checkOutput("sat_count", out_q.size() - base, 4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("sat_%0d", i), getOut(base + i), exp_sat[i]);

        $display("[TB] per-sample controls");
        doReset();
        base = out_q.size();
        applyStimulus(1'b1, -7, 1, 1, 1'b1);
        applyStimulus(1'b1, 0, 1, 1, 1'b1);
        applyStimulus(1'b1, 100, 2, 0, 1'b0);
        applyStimulus(1'b1, 50, 3, 0, 1'b1);
        applyStimulus(1'b1, 0, 2, 2, 1'b1);
        idleCycles(3);
        checkOutput("ctl_count", out_q.size() - base, 5);
        for (int i = 0; i < 5; i++) checkOutput($sformatf("ctl_%0d", i), getOut(base + i), exp_ctl[i]);

        $display("[TB] fill guard");
        doReset();
        for (int i = 0; i < 4096; i++) applyStimulus(1'b1, 32767, 0, 0, 1'b1);
        idleCycles(3);
        checkOutput("preload_fill_sat", fill_cnt, 4095);
        doReset();
        checkOutput("guard_fill_rst", fill_cnt, 0);
        base = out_q.size();
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, 100 * (i + 1), 10, 0, 1'b1);
        idleCycles(3);
        checkOutput("guard_count", out_q.size() - base, 11);
        for (int i = 0; i < 10; i++) checkOutput($sformatf("guard_%0d", i), getOut(base + i), 100 * (i + 1));
        checkOutput("guard_first_echo", getOut(base + 10), 1200);
        checkOutput("guard_fill", fill_cnt, 11);

        $display("[TB] wrap");
        doReset();
        base = out_q.size();
        for (int i = 0; i < 5000; i++) applyStimulus(1'b1, wrapIn(i), 4095, 0, 1'b1);
        idleCycles(3);
        checkOutput("wrap_count", out_q.size() - base, 5000);
        checkOutput("wrap_fill", fill_cnt, 4095);
        for (int i = 0; i < 5000; i++) begin
            checkOutput($sformatf("wrap_%0d", i), getOut(base + i),
                        wrapIn(i) + ((i >= 4095) ? wrapIn(i - 4095) : 0));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
